mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Downstream neighbour of the EX stage in the 16-bit pipelined CPU.
- Holds the EX/MEM pipeline register, the word-addressed data memory and the MEM/WB pipeline register.
- Drives the write-back triple (data, register, enable) into the register file.
- Exposes the M-stage result for forwarding and a debug read port for benches.

Parameters:
DEPTH, 1024, data memory size in 16-bit words
ADDR_W, 10, word-index width; DEPTH = 2**ADDR_W

Ports:
clk  in  1  pipeline clock; all state updates on falling edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a real instruction
ex_alu_out  in  16  ALU result / byte address
ex_store_data  in  16  RD2 value for stores
ex_wr  in  2  destination register
ex_regwrite  in  1  instruction writes register file
ex_memtoreg  in  1  write-back source is memory
ex_memwrite  in  1  instruction is a store
ex_ir  in  16  instruction word, monitoring only
hold  in  1  stall: freeze M stage, bubble into WB
mem_fwd_data  out  16  EX/MEM alu_out
mem_fwd_reg  out  2  EX/MEM destination register
mem_fwd_en  out  1  M stage valid & regwrite & !memtoreg & wr!=0
wb_data  out  16  write-back data
wb_reg  out  2  write-back register
wb_en  out  1  register-file write enable
wb_ir  out  16  instruction in WB, monitoring only
misalign  out  1  sticky: odd-address access seen
dbg_addr  in  ADDR_W  debug word index
dbg_rdata  out  16  combinational dmem[dbg_addr]

Behaviour:
- Reset (rst_n low, async): both pipeline registers cleared (valid=0, controls=0, data=0, ir=0). All outputs 0 except dbg_rdata. misalign=0. Memory contents are NOT cleared.
- Reset mid-operation: in-flight instructions are discarded. A store whose falling edge coincides with rst_n low does not write.
- EX/MEM register, falling edge, hold=0: captures all ex_* inputs. If ex_valid=0, captures a bubble (valid=0, regwrite/memwrite/memtoreg=0).
- EX/MEM register, hold=1: retains its contents.
- Address decode: idx = m_alu_out[ADDR_W:1]; upper bits ignored, so addresses wrap modulo 2*DEPTH bytes. m_alu_out[0]=1 is a misaligned access.
- Store, falling edge: dmem[idx] <= m_store_data when m_valid & m_memwrite & !hold & !m_alu_out[0] & rst_n. At most one write per instruction.
- Load: dmem[idx] is read combinationally from current M-stage state.
- Misaligned access (load or store, m_valid=1, bit0=1):
  - store suppressed; load does not write back
  - misalign set at the edge the instruction leaves M; stays set until reset
- MEM/WB register, falling edge, hold=0: valid, wr, ir advance from M.
  - data = m_memtoreg ? dmem[idx] : m_alu_out
  - en = m_valid & m_regwrite & (m_wr!=0) & !(m_memtoreg & misaligned)
- MEM/WB register, hold=1: captures a bubble (wb_en=0, wb_data=0, wb_reg=0, wb_ir=0).
- Latency: an instruction captured from EX at falling edge N appears on mem_fwd_* after N and on wb_* after N+1. Each hold edge adds one cycle.
- Register 0: never written; wb_en and mem_fwd_en are forced 0 when the destination is 0.
- Store followed immediately by a load to the same word: the store writes at the edge it leaves M; the load then sits in M and reads the new value. No hazard inside the block.
- Store-only and bubble instructions produce wb_en=0.

Test Plan:
1. Reset: run traffic, pull rst_n low between edges -> wb_en=0, wb_data=0, mem_fwd_en=0, misalign=0 immediately. dbg_rdata still shows previously stored data.
2. ALU pass-through: alu_out=0x0016, wr=3, regwrite=1, memtoreg=0 -> after edge 1, mem_fwd_data=0x0016 and mem_fwd_en=1. After edge 2, wb_data=0x0016, wb_reg=3, wb_en=1.
3. Store then load back-to-back: sw data=0x00AB at alu_out=0x0004, then lw alu_out=0x0004, wr=2, memtoreg=1 -> dbg_addr=2 reads 0x00AB; lw gives wb_data=0x00AB, wb_reg=2, wb_en=1.
4. Hold: store 0x1234 at 0x0010 in M, hold=1 for 2 edges -> wb_en=0 on both edges. dmem[8] is written exactly once, on the first edge with hold=0.
5. Misaligned: sw at 0x0005 -> dmem[2] unchanged, misalign=1. Next lw at 0x0003 -> wb_en=0. misalign stays 1 until rst_n low.
6. Wrap and r0: sw 0x5555 at 0x0800 (DEPTH=1024) -> dmem[0]=0x5555. add with wr=0, regwrite=1 -> wb_en=0, mem_fwd_en=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// M and WB stages of the 16-bit pipeline: EX/MEM register, word-addressed data memory,
// MEM/WB register, forwarding tap for the M-stage result and a debug read port.
module mem_wb_stage #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [15:0]       ex_alu_out,
    input  logic [15:0]       ex_store_data,
    input  logic [1:0]        ex_wr,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_memwrite,
    input  logic [15:0]       ex_ir,
    input  logic              hold,
    output logic [15:0]       mem_fwd_data,
    output logic [1:0]        mem_fwd_reg,
    output logic              mem_fwd_en,
    output logic [15:0]       wb_data,
    output logic [1:0]        wb_reg,
    output logic              wb_en,
    output logic [15:0]       wb_ir,
    output logic              misalign,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_rdata
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 2;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu_out;
        logic [DW-1:0] store_data;
        logic [RW-1:0] wr;
        logic          regwrite;
        logic          memtoreg;
        logic          memwrite;
        logic          fwd_en;
        logic [DW-1:0] ir;
    } m_stage_t;

    m_stage_t          r_m;
    m_stage_t          w_m_next;
    logic [DW-1:0]     r_dmem [DEPTH];
    logic [DW-1:0]     r_wb_data;
    logic [RW-1:0]     r_wb_reg;
    logic              r_wb_en;
    logic [DW-1:0]     r_wb_ir;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_idx;
    logic              w_misaligned;
    logic              w_store;
    logic [DW-1:0]     w_rdata;
    logic [DW-1:0]     w_wb_data;
    logic              w_wb_en;

    // Next EX/MEM contents; an invalid EX slot becomes a bubble with all controls cleared
    always_comb begin
        w_m_next            = '0;
        w_m_next.valid      = ex_valid;
        w_m_next.alu_out    = ex_alu_out;
        w_m_next.store_data = ex_store_data;
        w_m_next.wr         = ex_wr;
        w_m_next.ir         = ex_ir;
        w_m_next.regwrite   = ex_valid & ex_regwrite;
        w_m_next.memtoreg   = ex_valid & ex_memtoreg;
        w_m_next.memwrite   = ex_valid & ex_memwrite;
        // Forward enable is precomputed so the tap comes straight off a flop
        w_m_next.fwd_en     = ex_valid & ex_regwrite & ~ex_memtoreg & (ex_wr != RW'(0));
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
        end else if (!hold) begin
            r_m <= w_m_next;
        end
    end

    // Byte address to word index; bits above ADDR_W are ignored so accesses wrap
    assign w_idx        = r_m.alu_out[ADDR_W:1];
    assign w_misaligned = r_m.valid & (r_m.memwrite | r_m.memtoreg) & r_m.alu_out[0];
    assign w_store      = r_m.valid & r_m.memwrite & ~hold & ~r_m.alu_out[0] & rst_n;
    assign w_rdata      = r_dmem[w_idx];

    // Memory contents deliberately survive reset
    always_ff @(negedge clk) begin
        if (w_store) begin
            r_dmem[w_idx] <= r_m.store_data;
        end
    end

    assign w_wb_data = r_m.memtoreg ? w_rdata : r_m.alu_out;
    assign w_wb_en   = r_m.valid & r_m.regwrite & (r_m.wr != RW'(0))
                     & ~(r_m.memtoreg & r_m.alu_out[0]);

    // A held M stage sends a bubble into WB
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data  <= '0;
            r_wb_reg   <= '0;
            r_wb_en    <= 1'b0;
            r_wb_ir    <= '0;
            r_misalign <= 1'b0;
        end else if (hold) begin
            r_wb_data  <= '0;
            r_wb_reg   <= '0;
            r_wb_en    <= 1'b0;
            r_wb_ir    <= '0;
        end else begin
            r_wb_data  <= w_wb_data;
            r_wb_reg   <= r_m.wr;
            r_wb_en    <= w_wb_en;
            r_wb_ir    <= r_m.ir;
            r_misalign <= r_misalign | w_misaligned;
        end
    end

    assign mem_fwd_data = r_m.alu_out;
    assign mem_fwd_reg  = r_m.wr;
    assign mem_fwd_en   = r_m.fwd_en;
    assign wb_data      = r_wb_data;
    assign wb_reg       = r_wb_reg;
    assign wb_en        = r_wb_en;
    assign wb_ir        = r_wb_ir;
    assign misalign     = r_misalign;
    assign dbg_rdata    = r_dmem[dbg_addr];

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for pipeline flow plus hand sequences
// for hold, misalignment and mid-run reset.
module tb_mem_wb_stage;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_store_data;
    logic [1:0]  ex_wr;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_memwrite;
    logic [15:0] ex_ir;
    logic        hold;
    logic [15:0] mem_fwd_data;
    logic [1:0]  mem_fwd_reg;
    logic        mem_fwd_en;
    logic [15:0] wb_data;
    logic [1:0]  wb_reg;
    logic        wb_en;
    logic [15:0] wb_ir;
    logic        misalign;
    logic [9:0]  dbg_addr;
    logic [15:0] dbg_rdata;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .ex_wr(ex_wr), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_ir(ex_ir), .hold(hold),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_en(mem_fwd_en),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en), .wb_ir(wb_ir),
        .misalign(misalign), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [1:0]  wr;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [15:0] ir;
        logic [15:0] e_fd;
        logic [1:0]  e_fr;
        logic        e_fe;
        logic [15:0] e_wd;
        logic [1:0]  e_wr;
        logic        e_we;
        logic [15:0] e_wi;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [1:0] wr, input logic rw, input logic m2r,
                         input logic mw, input logic [15:0] ir, input logic h);
        ex_valid      = v;
        ex_alu_out    = alu;
        ex_store_data = sd;
        ex_wr         = wr;
        ex_regwrite   = rw;
        ex_memtoreg   = m2r;
        ex_memwrite   = mw;
        ex_ir         = ir;
        hold          = h;
    endtask

    task automatic bubble();
        drive(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic peek(input logic [9:0] a, input string name, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_rdata, exp);
    endtask

    initial begin
        //            v  alu       sd        wr  rw m2r mw ir        fd        fr  fe wd        wr  we wi
        vecs[0] = '{1'b1, 16'h0016, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1000,
                    16'h0016, 2'd3, 1'b1, 16'h0000, 2'd0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 16'h0004, 16'h00AB, 2'd0, 1'b0, 1'b0, 1'b1, 16'h1001,
                    16'h0004, 2'd0, 1'b0, 16'h0016, 2'd3, 1'b1, 16'h1000};
        vecs[2] = '{1'b1, 16'h0004, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0, 16'h1002,
                    16'h0004, 2'd2, 1'b0, 16'h0004, 2'd0, 1'b0, 16'h1001};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000,
                    16'h0000, 2'd0, 1'b0, 16'h00AB, 2'd2, 1'b1, 16'h1002};
        vecs[4] = '{1'b1, 16'h0800, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b1, 16'h1004,
                    16'h0800, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 16'h0077, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'h1005,
                    16'h0077, 2'd0, 1'b0, 16'h0800, 2'd0, 1'b0, 16'h1004};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000,
                    16'h0000, 2'd0, 1'b0, 16'h0077, 2'd0, 1'b0, 16'h1005};

        rst_n    = 1'b0;
        dbg_addr = '0;
        bubble();
        #2;
        chk("rst_wb_en",   16'(wb_en), 16'h0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_fwd_en",  16'(mem_fwd_en), 16'h0);
        chk("rst_misalign", 16'(misalign), 16'h0);
        @(posedge clk);
        rst_n = 1'b1;

        // Pipeline flow: ALU pass-through, store->load, wrap store, r0 write
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].alu, vecs[i].sd, vecs[i].wr, vecs[i].rw,
                  vecs[i].m2r, vecs[i].mw, vecs[i].ir, 1'b0);
            edge_step();
            chk($sformatf("v%0d_fwd_data", i), mem_fwd_data, vecs[i].e_fd);
            chk($sformatf("v%0d_fwd_reg", i), 16'(mem_fwd_reg), 16'(vecs[i].e_fr));
            chk($sformatf("v%0d_fwd_en", i), 16'(mem_fwd_en), 16'(vecs[i].e_fe));
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wd);
            chk($sformatf("v%0d_wb_reg", i), 16'(wb_reg), 16'(vecs[i].e_wr));
            chk($sformatf("v%0d_wb_en", i), 16'(wb_en), 16'(vecs[i].e_we));
            chk($sformatf("v%0d_wb_ir", i), wb_ir, vecs[i].e_wi);
        end
        peek(10'd2, "dmem2_after_sw", 16'h00AB);
        peek(10'd0, "dmem0_wrap", 16'h5555);

        // Hold: store stays in M, WB gets bubbles, write happens on release edge
        drive(1'b1, 16'h0010, 16'hDEAD, 2'd0, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b0);
        edge_step();
        bubble();
        edge_step();
        drive(1'b1, 16'h0010, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1, 16'h2001, 1'b0);
        edge_step();
        peek(10'd8, "hold_pre", 16'hDEAD);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 16'h0099, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, 16'h2002, 1'b1);
            edge_step();
            chk($sformatf("hold%0d_wb_en", k), 16'(wb_en), 16'h0);
            chk($sformatf("hold%0d_wb_ir", k), wb_ir, 16'h0);
            chk($sformatf("hold%0d_wb_data", k), wb_data, 16'h0);
            chk($sformatf("hold%0d_fwd_data", k), mem_fwd_data, 16'h0010);
            peek(10'd8, $sformatf("hold%0d_dmem8", k), 16'hDEAD);
        end
        bubble();
        edge_step();
        peek(10'd8, "release_dmem8", 16'h1234);
        chk("release_wb_ir", wb_ir, 16'h2001);
        chk("release_wb_en", 16'(wb_en), 16'h0);
        chk("release_fwd_data", mem_fwd_data, 16'h0000);

        // Misaligned store then misaligned load
        drive(1'b1, 16'h0005, 16'h9999, 2'd0, 1'b0, 1'b0, 1'b1, 16'h3000, 1'b0);
        edge_step();
        chk("mis_not_yet", 16'(misalign), 16'h0);
        drive(1'b1, 16'h0003, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 16'h3001, 1'b0);
        edge_step();
        peek(10'd2, "mis_dmem2", 16'h00AB);
        chk("mis_set", 16'(misalign), 16'h1);
        bubble();
        edge_step();
        chk("mis_lw_wb_en", 16'(wb_en), 16'h0);
        chk("mis_lw_wb_ir", wb_ir, 16'h3001);
        drive(1'b1, 16'h0022, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, 16'h3002, 1'b0);
        edge_step();
        bubble();
        edge_step();
        chk("post_mis_wb_en", 16'(wb_en), 16'h1);
        chk("post_mis_wb_data", wb_data, 16'h0022);
        chk("mis_sticky", 16'(misalign), 16'h1);

        // Reset between edges with a store in M
        drive(1'b1, 16'h0004, 16'h7777, 2'd0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0);
        edge_step();
        chk("pre_rst_fwd_data", mem_fwd_data, 16'h0004);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_wb_en", 16'(wb_en), 16'h0);
        chk("mrst_wb_data", wb_data, 16'h0);
        chk("mrst_wb_ir", wb_ir, 16'h0);
        chk("mrst_fwd_en", 16'(mem_fwd_en), 16'h0);
        chk("mrst_fwd_data", mem_fwd_data, 16'h0);
        chk("mrst_misalign", 16'(misalign), 16'h0);
        peek(10'd2, "mrst_dmem2", 16'h00AB);
        peek(10'd0, "mrst_dmem0", 16'h5555);
        edge_step();
        peek(10'd2, "rst_edge_dmem2", 16'h00AB);
        chk("rst_edge_fwd_data", mem_fwd_data, 16'h0);
        @(posedge clk);
        rst_n = 1'b1;
        bubble();
        edge_step();
        peek(10'd2, "after_rst_dmem2", 16'h00AB);
        chk("after_rst_wb_en", 16'(wb_en), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
